gpio_expander_spi_ctrl: RTL



---
 rtl/gpio_exp_pkg.sv | 33 +++
 rtl/gpio_exp_delay_cnt.sv | 29 ++
 rtl/gpio_expander_spi_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/gpio_exp_pkg.sv
// Shared types and constants for the SPI GPIO-expander transaction sequencer.
package gpio_exp_pkg;

  // Sequencer states. INIT is only reachable when GPIO_EXP_AUTO_INIT_EN is defined.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_SETUP,
    ST_ISSUE,
    ST_WAIT_RX,
    ST_HOLD,
    ST_GAP
  } state_t;

  localparam logic [3:0] OPCODE_BASE   = 4'b0100;
  localparam logic [7:0] IOCON_ADDR    = 8'h0A;
  localparam logic [7:0] IOCON_HAEN    = 8'h08;
  localparam logic [7:0] DUMMY_BYTE    = 8'h00;
  localparam logic [1:0] LAST_BYTE_IDX = 2'd2;

  // Largest of three timing parameters; sizes the shared delay counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Expander opcode byte: fixed base, hardware address, R/W bit (1 = read).
  function automatic logic [7:0] make_opcode(input logic [2:0] hw_addr, input logic write);
    return {OPCODE_BASE, hw_addr, ~write};
  endfunction

endpackage

// File: rtl/gpio_exp_delay_cnt.sv
// Loadable down-counter with a zero flag. Loading N gives the zero flag
// N cycles later, so a state that waits for zero lasts N+1 cycles.
module gpio_exp_delay_cnt #(
  parameter int W = 2
) (
  input  logic         i_Clk,
  input  logic         i_Rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  // Load takes priority; otherwise count down and park at zero.
  always_ff @(posedge i_Clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    if (i_Rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/gpio_expander_spi_ctrl.sv
// Transaction sequencer for the SPI GPIO expander: frames one register
// read/write as a 3-byte chip-selected transfer (opcode, address, data/dummy)
// and drives the byte-level SPI master through its TX/RX handshake.
// Optional build macro: GPIO_EXP_AUTO_INIT_EN -- after reset, write
// IOCON <= HAEN using the broadcast address before accepting requests.
module gpio_expander_spi_ctrl
  import gpio_exp_pkg::*;
#(
  parameter logic [2:0] HW_ADDR       = 3'b000,
  parameter int         CS_SETUP_CLKS = 2,
  parameter int         CS_HOLD_CLKS  = 2,
  parameter int         CS_IDLE_CLKS  = 4
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Req_Valid,
  input  logic       i_Req_Write,
  input  logic [7:0] i_Req_Addr,
  input  logic [7:0] i_Req_Data,
  output logic       o_Req_Ready,
  output logic       o_Done,
  output logic [7:0] o_Rsp_Data,
  output logic [7:0] o_TX_Byte,
  output logic       o_TX_DV,
  input  logic       i_TX_Ready,
  input  logic       i_RX_DV,
  input  logic [7:0] i_RX_Byte,
  output logic       o_SPI_CS_n
);

  localparam int CNT_W = $clog2(max3(CS_SETUP_CLKS, CS_HOLD_CLKS, CS_IDLE_CLKS) + 1);

  // The counter is loaded on the edge that enters a timed state, so each
  // load is one less than the number of cycles that state must last.
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(CS_SETUP_CLKS - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(CS_HOLD_CLKS - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(CS_IDLE_CLKS - 1);

`ifdef GPIO_EXP_AUTO_INIT_EN
  localparam state_t RESET_STATE = ST_INIT;
`else
  localparam state_t RESET_STATE = ST_IDLE;
`endif

  state_t           state;
  logic [1:0]       byte_idx;
  logic             req_write;
  logic [7:0]       req_addr;
  logic [7:0]       req_data;
  logic             init_active;
  logic             accept;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_zero;
  logic [7:0]       cur_byte;

  assign accept = (state == ST_IDLE) && i_Req_Valid && o_Req_Ready;

  // Counter load requests, issued on the edge that enters SETUP, HOLD or GAP.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a latch.
    cnt_load = 1'b0;
    cnt_val  = '0;
    case (state)
      ST_INIT: begin
        cnt_load = 1'b1;
        cnt_val  = SETUP_LD;
      end
      ST_IDLE: begin
        if (accept) begin
          cnt_load = 1'b1;
          cnt_val  = SETUP_LD;
        end
      end
      ST_WAIT_RX: begin
        if (i_RX_DV && (byte_idx == LAST_BYTE_IDX)) begin
          cnt_load = 1'b1;
          cnt_val  = HOLD_LD;
        end
      end
      ST_HOLD: begin
        if (cnt_zero) begin
          cnt_load = 1'b1;
          cnt_val  = GAP_LD;
        end
      end
      default: ;
    endcase
  end

  // Byte mux: opcode, register address, then write data or dummy.
  // The init write always uses hardware address 0 since HAEN is not yet set.
  always_comb begin
    case (byte_idx)
      2'd0:    cur_byte = make_opcode(init_active ? 3'b000 : HW_ADDR, req_write);
      2'd1:    cur_byte = req_addr;
      default: cur_byte = req_write ? req_data : DUMMY_BYTE;
    endcase
  end

  gpio_exp_delay_cnt #(.W(CNT_W)) u_delay_cnt (
    .i_Clk    (i_Clk),
    .i_Rst    (i_Rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  // Transaction FSM with registered SPI-side and user-side outputs.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state       <= RESET_STATE;
      byte_idx    <= 2'd0;
      req_write   <= 1'b0;
      req_addr    <= 8'h00;
      req_data    <= 8'h00;
      init_active <= 1'b0;
      o_Req_Ready <= 1'b0;
      o_Done      <= 1'b0;
      o_Rsp_Data  <= 8'h00;
      o_TX_Byte   <= 8'h00;
      o_TX_DV     <= 1'b0;
      o_SPI_CS_n  <= 1'b1;
    end else begin
      o_TX_DV <= 1'b0;
      o_Done  <= 1'b0;
      case (state)
        ST_INIT: begin
          req_write   <= 1'b1;
          req_addr    <= IOCON_ADDR;
          req_data    <= IOCON_HAEN;
          init_active <= 1'b1;
          byte_idx    <= 2'd0;
          o_SPI_CS_n  <= 1'b0;
          state       <= ST_SETUP;
        end
        ST_IDLE: begin
          o_Req_Ready <= 1'b1;
          if (accept) begin
            req_write   <= i_Req_Write;
            req_addr    <= i_Req_Addr;
            req_data    <= i_Req_Data;
            byte_idx    <= 2'd0;
            o_Req_Ready <= 1'b0;
            o_SPI_CS_n  <= 1'b0;
            state       <= ST_SETUP;
          end
        end
        // The last setup cycle fires byte 0 directly when the master is ready,
        // so the first TX_DV lands exactly CS_SETUP_CLKS after CS_n falls.
        ST_SETUP: begin
          if (cnt_zero) begin
            if (i_TX_Ready) begin
              o_TX_DV   <= 1'b1;
              o_TX_Byte <= cur_byte;
              state     <= ST_WAIT_RX;
            end else begin
              state <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (i_TX_Ready) begin
            o_TX_DV   <= 1'b1;
            o_TX_Byte <= cur_byte;
            state     <= ST_WAIT_RX;
          end
        end
        ST_WAIT_RX: begin
          if (i_RX_DV) begin
            if (byte_idx != LAST_BYTE_IDX) begin
              byte_idx <= byte_idx + 2'd1;
              state    <= ST_ISSUE;
            end else begin
              if (!req_write) begin
                o_Rsp_Data <= i_RX_Byte;
              end
              state <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (cnt_zero) begin
            o_SPI_CS_n <= 1'b1;
            o_Done     <= ~init_active;
            state      <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (cnt_zero) begin
            init_active <= 1'b0;
            o_Req_Ready <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
